// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous BIOS/IMEM
// reads and presents one instruction per cycle with its PC to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [11:0] bios_addra,
  input  logic [31:0] bios_douta,
  output logic [13:0] imem_addrb,
  input  logic [31:0] imem_doutb,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    SRC_BIOS = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_NONE = 2'd2
  } src_e;

  logic [31:0] pc;
  logic [31:0] next_pc;
  src_e        src_q;
  src_e        next_src;
  logic        misaligned_redirect;

  function automatic src_e region_of(input logic [31:0] addr);
    case (addr[31:28])
      4'b0100:         return SRC_BIOS;
      4'b0001, 4'b0010: return SRC_IMEM;
      default:         return SRC_NONE;
    endcase
  endfunction

  // Stall is a replay: re-present pc so the memories reread the same word,
  // which keeps if_inst stable without a skid buffer. Redirect beats stall.
  always_comb begin
    // NOTE: every path assigns next_pc, so no latch is inferred.
    next_pc = pc + 32'd4;
    if (rst || !if_valid)  next_pc = RESET_PC;
    else if (redirect_valid) next_pc = {redirect_pc[31:2], 2'b00};
    else if (stall)          next_pc = pc;
  end

  assign next_src            = region_of(next_pc);
  assign misaligned_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Both buses follow next_pc unconditionally; src_q picks the right one later.
  assign bios_addra = next_pc[13:2];
  assign imem_addrb = next_pc[15:2];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      src_q       <= SRC_BIOS;
      if_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      pc       <= next_pc;
      src_q    <= next_src;
      if_valid <= 1'b1;
      if (next_src == SRC_NONE || misaligned_redirect)
        fetch_fault <= 1'b1;
    end
  end

  assign if_pc = pc;

  always_comb begin
    case (src_q)
      SRC_BIOS: if_inst = bios_douta;
      SRC_IMEM: if_inst = imem_doutb;
      default:  if_inst = NOP_INST;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with behavioural synchronous-read BIOS/IMEM.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] bios_addra;
  logic [31:0] bios_douta;
  logic [13:0] imem_addrb;
  logic [31:0] imem_doutb;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        fetch_fault;

  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bios_addra     (bios_addra),
    .bios_douta     (bios_douta),
    .imem_addrb     (imem_addrb),
    .imem_doutb     (imem_doutb),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bios_douta <= bios_mem[bios_addra];
    imem_doutb <= imem_mem[imem_addrb];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)  bios_mem[i] = 32'hB000_0000 | i;
    for (int i = 0; i < 16384; i++) imem_mem[i] = 32'hA000_0000 | i;
    bios_mem[0] = 32'h00a00093;
    bios_mem[1] = 32'h00200a13;
    bios_mem[2] = 32'h00100093;
    imem_mem[4] = 32'hdeadbeef;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step(); step();
    check("reset_valid", {31'd0, if_valid}, 32'd0);
    check("reset_pc", if_pc, 32'h4000_0000);
    check("reset_fault", {31'd0, fetch_fault}, 32'd0);
    check("reset_bios_addr", {20'd0, bios_addra}, 32'd0);

    // Startup: E0 is the next edge
    rst = 1'b0;
    step();
    check("run0_pc", if_pc, 32'h4000_0000);
    check("run0_inst", if_inst, 32'h00a00093);
    check("run0_valid", {31'd0, if_valid}, 32'd1);
    step();
    check("run1_pc", if_pc, 32'h4000_0004);
    check("run1_inst", if_inst, 32'h00200a13);

    // Stall 3 cycles at 4000_0004
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_pc, 32'h4000_0004);
      check("stall_inst", if_inst, 32'h00200a13);
      check("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("release_pc", if_pc, 32'h4000_0008);
    check("release_inst", if_inst, 32'h00100093);
    check("release_fault", {31'd0, fetch_fault}, 32'd0);

    // Redirect into IMEM
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0010;
    step();
    redirect_valid = 1'b0;
    #1;
    check("imem_pc", if_pc, 32'h1000_0010);
    check("imem_inst", if_inst, 32'hdeadbeef);
    check("imem_addr", {18'd0, imem_addrb}, 32'd5);
    check("imem_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    check("imem_next_pc", if_pc, 32'h1000_0014);
    check("imem_next_inst", if_inst, 32'hA000_0005);

    // Stall and redirect together: redirect wins, target then held
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000_0020;
    step();
    redirect_valid = 1'b0;
    check("sr_pc", if_pc, 32'h4000_0020);
    check("sr_inst", if_inst, 32'hB000_0008);
    for (int i = 0; i < 2; i++) begin
      step();
      check("sr_hold_pc", if_pc, 32'h4000_0020);
      check("sr_hold_inst", if_inst, 32'hB000_0008);
    end
    stall = 1'b0;
    step();
    check("sr_release_pc", if_pc, 32'h4000_0024);
    check("sr_release_inst", if_inst, 32'hB000_0009);

    // Unmapped redirect, then misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    step();
    check("unmapped_pc", if_pc, 32'h8000_0000);
    check("unmapped_inst", if_inst, 32'h0000_0013);
    check("unmapped_fault", {31'd0, fetch_fault}, 32'd1);
    redirect_pc = 32'h4000_0002;
    step();
    redirect_valid = 1'b0;
    check("misalign_pc", if_pc, 32'h4000_0000);
    check("misalign_inst", if_inst, 32'h00a00093);
    check("misalign_fault", {31'd0, fetch_fault}, 32'd1);
    step();
    check("adv_pc", if_pc, 32'h4000_0004);
    step();
    check("adv2_pc", if_pc, 32'h4000_0008);

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    check("async_valid", {31'd0, if_valid}, 32'd0);
    check("async_pc", if_pc, 32'h4000_0000);
    check("async_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("restart0_pc", if_pc, 32'h4000_0000);
    check("restart0_inst", if_inst, 32'h00a00093);
    check("restart0_valid", {31'd0, if_valid}, 32'd1);

    // Misaligned redirect into a mapped region alone sets the fault
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0006;
    step();
    redirect_valid = 1'b0;
    check("mis_only_pc", if_pc, 32'h4000_0004);
    check("mis_only_inst", if_inst, 32'h00200a13);
    check("mis_only_fault", {31'd0, fetch_fault}, 32'd1);

    // Wrap from FFFF_FFFC to 0
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("top_pc", if_pc, 32'hFFFF_FFFC);
    check("top_inst", if_inst, 32'h0000_0013);
    step();
    check("wrap_pc", if_pc, 32'h0000_0000);
    check("wrap_inst", if_inst, 32'h0000_0013);
    check("wrap_valid", {31'd0, if_valid}, 32'd1);
    check("wrap_fault", {31'd0, fetch_fault}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
